trap_ctrl_unit: RTL and testbench
=================================

Name: trap_ctrl_unit

Overview:
- Parametrised successor to the pipeline exception unit.
- Owns the machine-mode CSR file internally: mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch.
- Arbitrates NUM_IRQ interrupt lines against synchronous exceptions and sequences trap entry and mret with a small FSM.
- Drives PC redirect, pipeline flushes and write-back cancel from the MEM/WB boundary.

Parameters:
- XLEN, 32, CSR/PC data width.
- NUM_IRQ, 4, number of level-sensitive interrupt inputs; irq[i] maps to mcause code 16+i; range 1..16.
- MTVEC_RESET, 0, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csr_rw_in  in  1  CSR instruction valid in MEM
- csr_wsc_mode_in  in  2  01 write, 10 set, 11 clear
- csr_w_imm_mux  in  1  1: write operand is zero-extended csr_w_data_imm
- csr_rw_addr_in  in  12  CSR address
- csr_w_data_reg  in  XLEN  rs1 data
- csr_w_data_imm  in  5  zimm
- csr_r_data_out  out  XLEN  combinational read of the addressed CSR (old value)
- csr_addr_illegal  out  1  csr_rw_in with an unimplemented address
- irq  in  NUM_IRQ  level interrupt requests
- illegal_inst, ecall_m, l_access_fault, s_access_fault  in  1 each  exception flags of the WB instruction
- bad_addr  in  XLEN  faulting data address, for mtval
- mret  in  1  mret in WB
- epc_cur  in  XLEN  PC of the WB instruction
- epc_next  in  XLEN  oldest unflushed younger PC
- PC_redirect  out  XLEN  redirect target
- redirect_mux  out  1  redirect valid
- reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  out  1 each
- RegWrite_cancel  out  1  suppress WB write
- trap_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - mstatus, mie, mip, mepc, mcause, mtval, mscratch all 0.
  - mtvec = MTVEC_RESET.
- mip[16+i] is registered from irq[i] every cycle. Software writes to mip are ignored.
- Interrupt pending: int_pend = mstatus.MIE(bit3) & |(mip[16+:NUM_IRQ] & mie[16+:NUM_IRQ]). The lowest index wins.
- Exception priority: illegal_inst (cause 2) > ecall_m (11) > l_access_fault (5) > s_access_fault (7).
- An interrupt beats any exception.
- mtval:
  - bad_addr for access faults.
  - 0 for ecall and interrupts.
  - 0 for illegal_inst.
- FSM states IDLE, TRAP, RET.
- IDLE:
  - If int_pend or any exception:
    - Assert all four flushes combinationally.
    - Assert RegWrite_cancel for exceptions only; the interrupted instruction retires.
    - Latch cause, tval and epc: epc_cur for exceptions, epc_next for interrupts.
    - Go to TRAP.
  - Else if mret: assert flushes and go to RET.
  - Else CSR access: the write commits at the clock edge.
    - Write 01: new = op. Set 10: new = old|op. Clear 11: new = old&~op.
    - If op == 0 on set/clear, no write occurs.
- TRAP (exactly 1 cycle):
  - Write mepc (bit 0 forced 0), mcause (bit XLEN-1 = 1 for interrupts), mtval.
  - Update mstatus: MPIE <= MIE, MIE <= 0, MPP(12:11) <= 11.
  - Assert redirect_mux and all flushes.
  - PC_redirect = {mtvec[XLEN-1:2],2'b00}, plus 4*code when mtvec[1:0]==01 and the trap is an interrupt.
  - Return to IDLE.
- RET (1 cycle):
  - redirect_mux=1, PC_redirect=mepc, flushes=1.
  - Update mstatus: MIE <= MPIE, MPIE <= 1.
  - Return to IDLE.
- trap_busy = (state != IDLE).
- While busy:
  - Exception, mret and CSR write inputs are ignored.
  - Interrupts are re-evaluated only in IDLE.
- CSR write coincident with a trap or mret in IDLE: the trap wins and the CSR write is dropped.
- Trap latency: detect cycle N, redirect at cycle N+1, first handler fetch at N+2.
- An mret while MIE=0 with MPIE=1 and an interrupt pending: the interrupt is taken in the first IDLE cycle after RET.
- mtvec writes force bit 1 to 0.
- rst asserted mid-TRAP or mid-RET: return to IDLE and reset values at that edge; no partial CSR update persists.

Test Plan:
- csrrw mtvec=0x100, then illegal_inst with epc_cur=0x40:
  - cycle N: flushes=1, RegWrite_cancel=1.
  - cycle N+1: redirect_mux=1, PC_redirect=0x100.
  - Afterwards mepc=0x40, mcause=2.
- mtvec=0x201 (vectored), mie[17]=1, MIE=1, irq[1]=1, epc_next=0x88:
  - PC_redirect=0x200+4*17=0x244.
  - mcause=0x80000011, mepc=0x88, RegWrite_cancel=0, MIE=0, MPIE=1.
- irq[0] and irq[2] both enabled and asserted together with an l_access_fault at bad_addr=0x1004: cause 0x80000010 is taken and mtval=0.
- Trap handled, then mret:
  - redirect to mepc.
  - MIE restored to 1; the still-pending irq retraps on the next IDLE cycle.
- csrrs mscratch with zimm=0 while mscratch=0x5: no write, and csr_r_data_out=0x5.
- rst asserted during TRAP:
  - next cycle trap_busy=0, mepc=0, mtvec=MTVEC_RESET.
  - redirect_mux=0.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundles the CSR access, exception/interrupt and redirect/flush
// signals of trap_ctrl_unit.
//   slave  : the trap unit (consumes CSR/exception inputs, drives redirect/flush)
//   master : the pipeline side (drives CSR/exception inputs, consumes redirect/flush)
interface trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  // CSR access from MEM
  logic              csr_rw_in;
  logic [1:0]        csr_wsc_mode_in;
  logic              csr_w_imm_mux;
  logic [11:0]       csr_rw_addr_in;
  logic [XLEN-1:0]   csr_w_data_reg;
  logic [4:0]        csr_w_data_imm;
  logic [XLEN-1:0]   csr_r_data_out;
  logic              csr_addr_illegal;
  // interrupts / exceptions / mret from WB
  logic [NUM_IRQ-1:0] irq;
  logic              illegal_inst, ecall_m, l_access_fault, s_access_fault;
  logic [XLEN-1:0]   bad_addr;
  logic              mret;
  logic [XLEN-1:0]   epc_cur, epc_next;
  // redirect / flush
  logic [XLEN-1:0]   PC_redirect;
  logic              redirect_mux;
  logic              reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic              RegWrite_cancel;
  logic              trap_busy;

  modport slave (
    input  csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
           csr_w_data_reg, csr_w_data_imm, irq, illegal_inst, ecall_m,
           l_access_fault, s_access_fault, bad_addr, mret, epc_cur, epc_next,
    output csr_r_data_out, csr_addr_illegal, PC_redirect, redirect_mux,
           reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
           RegWrite_cancel, trap_busy
  );

  modport master (
    output csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
           csr_w_data_reg, csr_w_data_imm, irq, illegal_inst, ecall_m,
           l_access_fault, s_access_fault, bad_addr, mret, epc_cur, epc_next,
    input  csr_r_data_out, csr_addr_illegal, PC_redirect, redirect_mux,
           reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
           RegWrite_cancel, trap_busy
  );
endinterface

// File: rtl/trap_ctrl_unit.sv
// trap_ctrl_unit: machine-mode CSR file plus trap/mret sequencer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : trap_ctrl_if.slave -- CSR read/write port, interrupt lines,
//              WB exception flags, mret, redirect target, flushes, WB cancel.
// A trap is detected in IDLE (flushes combinational), committed in TRAP
// (CSR update + redirect), so the handler is fetched two cycles after detect.
module trap_ctrl_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                          A_MTVAL = 12'h343, A_MIP = 12'h344;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d, mscratch_q, mscratch_d;
  // trap context captured at detect, committed to CSRs in TRAP
  logic [XLEN-1:0] cause_lat_q, cause_lat_d, tval_lat_q, tval_lat_d, epc_lat_q, epc_lat_d;

  // interrupt arbitration: lowest enabled pending line wins
  logic [NUM_IRQ-1:0] int_vec;
  logic               int_pend;
  logic [3:0]         int_idx;
  assign int_vec  = mip_q[16 +: NUM_IRQ] & mie_q[16 +: NUM_IRQ];
  assign int_pend = mstatus_q[3] & (|int_vec);

  always_comb begin
    int_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (int_vec[i]) int_idx = 4'(i);
  end

  logic            exc_any;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  assign exc_any = bus.illegal_inst | bus.ecall_m | bus.l_access_fault | bus.s_access_fault;

  always_comb begin
    exc_code = 5'd7;
    exc_tval = bus.bad_addr;
    if (bus.illegal_inst)        begin exc_code = 5'd2;  exc_tval = '0; end
    else if (bus.ecall_m)        begin exc_code = 5'd11; exc_tval = '0; end
    else if (bus.l_access_fault) exc_code = 5'd5;
  end

  // CSR read mux / legality
  logic [XLEN-1:0] csr_old, csr_op, csr_new;
  logic            csr_legal, csr_we;

  always_comb begin
    csr_legal = 1'b1;
    csr_old   = '0;
    case (bus.csr_rw_addr_in)
      A_MSTATUS:  csr_old = mstatus_q;
      A_MIE:      csr_old = mie_q;
      A_MTVEC:    csr_old = mtvec_q;
      A_MSCRATCH: csr_old = mscratch_q;
      A_MEPC:     csr_old = mepc_q;
      A_MCAUSE:   csr_old = mcause_q;
      A_MTVAL:    csr_old = mtval_q;
      A_MIP:      csr_old = mip_q;
      default:    csr_legal = 1'b0;
    endcase
  end

  assign csr_op = bus.csr_w_imm_mux ? XLEN'(bus.csr_w_data_imm) : bus.csr_w_data_reg;

  always_comb begin
    case (bus.csr_wsc_mode_in)
      2'b01:   csr_new = csr_op;
      2'b10:   csr_new = csr_old | csr_op;
      2'b11:   csr_new = csr_old & ~csr_op;
      default: csr_new = csr_old;
    endcase
  end

  // set/clear with a zero operand is a pure read
  assign csr_we = bus.csr_rw_in & csr_legal &
                  ((bus.csr_wsc_mode_in == 2'b01) | (bus.csr_wsc_mode_in[1] & (csr_op != '0)));

  logic            flush, cancel, redirect;
  logic [XLEN-1:0] pc_redir, vec_off;
  assign vec_off = XLEN'({cause_lat_q[4:0], 2'b00});

  always_comb begin
    state_d     = state_q;
    mstatus_d   = mstatus_q;
    mie_d       = mie_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    mscratch_d  = mscratch_q;
    cause_lat_d = cause_lat_q;
    tval_lat_d  = tval_lat_q;
    epc_lat_d   = epc_lat_q;
    mip_d       = '0;
    mip_d[16 +: NUM_IRQ] = bus.irq;
    flush    = 1'b0;
    cancel   = 1'b0;
    redirect = 1'b0;
    pc_redir = '0;

    case (state_q)
      S_IDLE: begin
        if (int_pend || exc_any) begin
          flush  = 1'b1;
          cancel = ~int_pend;  // the interrupted instruction still retires
          if (int_pend) begin
            cause_lat_d           = '0;
            cause_lat_d[XLEN-1]   = 1'b1;
            cause_lat_d[4:0]      = 5'd16 + 5'(int_idx);
            tval_lat_d            = '0;
            epc_lat_d             = bus.epc_next;
          end else begin
            cause_lat_d = XLEN'(exc_code);
            tval_lat_d  = exc_tval;
            epc_lat_d   = bus.epc_cur;
          end
          state_d = S_TRAP;
        end else if (bus.mret) begin
          flush   = 1'b1;
          state_d = S_RET;
        end else if (csr_we) begin
          case (bus.csr_rw_addr_in)
            A_MSTATUS:  mstatus_d  = csr_new;
            A_MIE:      mie_d      = csr_new;
            A_MTVEC:    mtvec_d    = csr_new & ~XLEN'(2);
            A_MSCRATCH: mscratch_d = csr_new;
            A_MEPC:     mepc_d     = csr_new & ~XLEN'(1);
            A_MCAUSE:   mcause_d   = csr_new;
            A_MTVAL:    mtval_d    = csr_new;
            default: ;  // mip is hardware-owned
          endcase
        end
      end
      S_TRAP: begin
        flush        = 1'b1;
        redirect     = 1'b1;
        pc_redir     = {mtvec_q[XLEN-1:2], 2'b00} +
                       (((mtvec_q[1:0] == 2'b01) && cause_lat_q[XLEN-1]) ? vec_off : '0);
        mepc_d       = epc_lat_q & ~XLEN'(1);
        mcause_d     = cause_lat_q;
        mtval_d      = tval_lat_q;
        mstatus_d[7]     = mstatus_q[3];
        mstatus_d[3]     = 1'b0;
        mstatus_d[12:11] = 2'b11;
        state_d      = S_IDLE;
      end
      S_RET: begin
        flush        = 1'b1;
        redirect     = 1'b1;
        pc_redir     = mepc_q;
        mstatus_d[3] = mstatus_q[7];
        mstatus_d[7] = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs held low while reset is applied
    if (rst) begin
      flush    = 1'b0;
      cancel   = 1'b0;
      redirect = 1'b0;
      pc_redir = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mstatus_q   <= '0;
      mie_q       <= '0;
      mip_q       <= '0;
      mtvec_q     <= MTVEC_RESET;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mscratch_q  <= '0;
      cause_lat_q <= '0;
      tval_lat_q  <= '0;
      epc_lat_q   <= '0;
    end else begin
      state_q     <= state_d;
      mstatus_q   <= mstatus_d;
      mie_q       <= mie_d;
      mip_q       <= mip_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mscratch_q  <= mscratch_d;
      cause_lat_q <= cause_lat_d;
      tval_lat_q  <= tval_lat_d;
      epc_lat_q   <= epc_lat_d;
    end
  end

  assign bus.csr_r_data_out   = csr_old;
  assign bus.csr_addr_illegal = bus.csr_rw_in & ~csr_legal & ~rst;
  assign bus.PC_redirect      = pc_redir;
  assign bus.redirect_mux     = redirect;
  assign bus.reg_FD_flush     = flush;
  assign bus.reg_DE_flush     = flush;
  assign bus.reg_EM_flush     = flush;
  assign bus.reg_MW_flush     = flush;
  assign bus.RegWrite_cancel  = cancel;
  assign bus.trap_busy        = (state_q != S_IDLE) & ~rst;
endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Directed bench for trap_ctrl_unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled a further unit later.
module tb_trap_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32), .NUM_IRQ(4)) bus ();
  trap_ctrl_unit #(.XLEN(32), .NUM_IRQ(4), .MTVEC_RESET(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                          A_MTVAL = 12'h343, A_MIP = 12'h344;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0; bus.csr_w_imm_mux = 0;
    bus.csr_rw_addr_in = 0; bus.csr_w_data_reg = 0; bus.csr_w_data_imm = 0;
    bus.irq = 0; bus.illegal_inst = 0; bus.ecall_m = 0; bus.l_access_fault = 0;
    bus.s_access_fault = 0; bus.bad_addr = 0; bus.mret = 0; bus.epc_cur = 0; bus.epc_next = 0;
  endtask

  // one CSR instruction held for one clock
  task automatic csr_op(input logic [1:0] mode, input logic imm, input logic [11:0] a,
                        input logic [31:0] d, input logic [4:0] z);
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = mode; bus.csr_w_imm_mux = imm;
    bus.csr_rw_addr_in = a; bus.csr_w_data_reg = d; bus.csr_w_data_imm = z;
    step();
    bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus.csr_rw_addr_in = a; #1; v = bus.csr_r_data_out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle_inputs(); rst = 1; step(); step(); rst = 0; #1;
    n_cmp++; if (bus.trap_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.trap_busy); end
    n_cmp++; if ({bus.redirect_mux, bus.reg_FD_flush, bus.reg_MW_flush, bus.RegWrite_cancel} !== 4'b0) begin
      n_bad++; $display("FAIL rst_outs got %b want 0000", {bus.redirect_mux, bus.reg_FD_flush, bus.reg_MW_flush, bus.RegWrite_cancel}); end
    rd(A_MTVEC, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_mtvec got %h want 0", v); end
    rd(A_MSTATUS, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_mstatus got %h want 0", v); end
    bus.csr_rw_in = 1; bus.csr_rw_addr_in = 12'h7C0; #1;
    n_cmp++; if (bus.csr_addr_illegal !== 1'b1) begin n_bad++; $display("FAIL addr_illegal got %b want 1", bus.csr_addr_illegal); end
    bus.csr_rw_addr_in = A_MIE; #1;
    n_cmp++; if (bus.csr_addr_illegal !== 1'b0) begin n_bad++; $display("FAIL addr_legal got %b want 0", bus.csr_addr_illegal); end
    bus.csr_rw_in = 0;
  endtask

  task automatic test_exception();
    logic [31:0] v;
    csr_op(2'b01, 0, A_MTVEC, 32'h100, 0);
    bus.illegal_inst = 1; bus.epc_cur = 32'h40; #1;
    n_cmp++; if ({bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush, bus.RegWrite_cancel} !== 5'b11111) begin
      n_bad++; $display("FAIL exc_detect got %b want 11111", {bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush, bus.RegWrite_cancel}); end
    n_cmp++; if (bus.redirect_mux !== 1'b0) begin n_bad++; $display("FAIL exc_early_redir got %b want 0", bus.redirect_mux); end
    step();
    // inputs presented while busy must be ignored
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b01; bus.csr_rw_addr_in = A_MSCRATCH; bus.csr_w_data_reg = 32'hDEAD; #1;
    n_cmp++; if (bus.redirect_mux !== 1'b1 || bus.PC_redirect !== 32'h100) begin
      n_bad++; $display("FAIL exc_redir got %b/%h want 1/00000100", bus.redirect_mux, bus.PC_redirect); end
    n_cmp++; if (bus.trap_busy !== 1'b1) begin n_bad++; $display("FAIL exc_busy got %b want 1", bus.trap_busy); end
    step();
    bus.illegal_inst = 0; bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0;
    rd(A_MEPC, v);
    n_cmp++; if (v !== 32'h40) begin n_bad++; $display("FAIL exc_mepc got %h want 00000040", v); end
    rd(A_MCAUSE, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL exc_mcause got %h want 00000002", v); end
    rd(A_MSTATUS, v);
    n_cmp++; if (v !== 32'h1800) begin n_bad++; $display("FAIL exc_mstatus got %h want 00001800", v); end
    rd(A_MSCRATCH, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL busy_csr_drop got %h want 0", v); end
    n_cmp++; if (bus.trap_busy !== 1'b0) begin n_bad++; $display("FAIL exc_idle got %b want 0", bus.trap_busy); end
  endtask

  task automatic test_vectored_irq();
    logic [31:0] v;
    csr_op(2'b01, 0, A_MTVEC, 32'h203, 0);
    rd(A_MTVEC, v);
    n_cmp++; if (v !== 32'h201) begin n_bad++; $display("FAIL mtvec_bit1 got %h want 00000201", v); end
    csr_op(2'b01, 0, A_MIE, 32'h0002_0000, 0);
    csr_op(2'b01, 0, A_MSTATUS, 32'h8, 0);
    bus.irq = 4'b0010; bus.epc_next = 32'h88; bus.epc_cur = 32'h84;
    step();  // mip picks up irq at this edge
    n_cmp++; if (bus.reg_FD_flush !== 1'b1 || bus.RegWrite_cancel !== 1'b0) begin
      n_bad++; $display("FAIL irq_detect got %b%b want 10", bus.reg_FD_flush, bus.RegWrite_cancel); end
    step();
    n_cmp++; if (bus.redirect_mux !== 1'b1 || bus.PC_redirect !== 32'h244) begin
      n_bad++; $display("FAIL irq_vec_redir got %b/%h want 1/00000244", bus.redirect_mux, bus.PC_redirect); end
    step();
    rd(A_MCAUSE, v);
    n_cmp++; if (v !== 32'h8000_0011) begin n_bad++; $display("FAIL irq_mcause got %h want 80000011", v); end
    rd(A_MEPC, v);
    n_cmp++; if (v !== 32'h88) begin n_bad++; $display("FAIL irq_mepc got %h want 00000088", v); end
    rd(A_MSTATUS, v);
    n_cmp++; if (v !== 32'h1880) begin n_bad++; $display("FAIL irq_mstatus got %h want 00001880", v); end
    rd(A_MIP, v);
    n_cmp++; if (v !== 32'h0002_0000) begin n_bad++; $display("FAIL irq_mip got %h want 00020000", v); end
    n_cmp++; if (bus.reg_FD_flush !== 1'b0) begin n_bad++; $display("FAIL irq_masked got %b want 0", bus.reg_FD_flush); end
    bus.irq = 0; step();
  endtask

  task automatic test_irq_priority();
    logic [31:0] v;
    csr_op(2'b01, 0, A_MIE, 32'h0005_0000, 0);
    csr_op(2'b01, 0, A_MSTATUS, 32'h8, 0);
    bus.irq = 4'b0101; bus.epc_next = 32'h90; bus.epc_cur = 32'h8c;
    step();
    bus.l_access_fault = 1; bus.bad_addr = 32'h1004; #1;
    n_cmp++; if (bus.reg_FD_flush !== 1'b1 || bus.RegWrite_cancel !== 1'b0) begin
      n_bad++; $display("FAIL prio_detect got %b%b want 10", bus.reg_FD_flush, bus.RegWrite_cancel); end
    step();
    n_cmp++; if (bus.PC_redirect !== 32'h240) begin n_bad++; $display("FAIL prio_redir got %h want 00000240", bus.PC_redirect); end
    step();
    bus.l_access_fault = 0;
    rd(A_MCAUSE, v);
    n_cmp++; if (v !== 32'h8000_0010) begin n_bad++; $display("FAIL prio_mcause got %h want 80000010", v); end
    rd(A_MTVAL, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL prio_mtval got %h want 0", v); end
  endtask

  // irq[0]/irq[2] remain asserted from the previous test; MIE=0, MPIE=1
  task automatic test_mret_retrap();
    logic [31:0] v;
    bus.mret = 1; #1;
    n_cmp++; if (bus.reg_MW_flush !== 1'b1 || bus.redirect_mux !== 1'b0 || bus.RegWrite_cancel !== 1'b0) begin
      n_bad++; $display("FAIL mret_detect got %b%b%b want 100", bus.reg_MW_flush, bus.redirect_mux, bus.RegWrite_cancel); end
    step();
    bus.mret = 0; #1;
    n_cmp++; if (bus.redirect_mux !== 1'b1 || bus.PC_redirect !== 32'h90) begin
      n_bad++; $display("FAIL mret_redir got %b/%h want 1/00000090", bus.redirect_mux, bus.PC_redirect); end
    step();
    rd(A_MSTATUS, v);
    n_cmp++; if (v !== 32'h1888) begin n_bad++; $display("FAIL mret_mstatus got %h want 00001888", v); end
    n_cmp++; if (bus.reg_FD_flush !== 1'b1 || bus.trap_busy !== 1'b0) begin
      n_bad++; $display("FAIL retrap_detect got %b%b want 10", bus.reg_FD_flush, bus.trap_busy); end
    step();
    n_cmp++; if (bus.redirect_mux !== 1'b1 || bus.PC_redirect !== 32'h240) begin
      n_bad++; $display("FAIL retrap_redir got %b/%h want 1/00000240", bus.redirect_mux, bus.PC_redirect); end
    bus.irq = 0; step(); step();
  endtask

  task automatic test_csr_setclear();
    logic [31:0] v;
    csr_op(2'b01, 0, A_MSCRATCH, 32'h5, 0);
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b10; bus.csr_w_imm_mux = 1;
    bus.csr_rw_addr_in = A_MSCRATCH; bus.csr_w_data_imm = 0; #1;
    n_cmp++; if (bus.csr_r_data_out !== 32'h5) begin n_bad++; $display("FAIL csrrs0_read got %h want 00000005", bus.csr_r_data_out); end
    step(); bus.csr_rw_in = 0;
    rd(A_MSCRATCH, v);
    n_cmp++; if (v !== 32'h5) begin n_bad++; $display("FAIL csrrs0_keep got %h want 00000005", v); end
    csr_op(2'b10, 1, A_MSCRATCH, 0, 5'h12);
    rd(A_MSCRATCH, v);
    n_cmp++; if (v !== 32'h17) begin n_bad++; $display("FAIL csrrsi got %h want 00000017", v); end
    csr_op(2'b11, 0, A_MSCRATCH, 32'h3, 0);
    rd(A_MSCRATCH, v);
    n_cmp++; if (v !== 32'h14) begin n_bad++; $display("FAIL csrrc got %h want 00000014", v); end
    csr_op(2'b01, 0, A_MIP, 32'hFFFF_FFFF, 0);
    rd(A_MIP, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL mip_ro got %h want 0", v); end
    // CSR write in the same cycle as an ecall is dropped
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b01; bus.csr_w_imm_mux = 0;
    bus.csr_rw_addr_in = A_MSCRATCH; bus.csr_w_data_reg = 32'hAA;
    bus.ecall_m = 1; bus.epc_cur = 32'h55;
    step();
    bus.csr_rw_in = 0; bus.ecall_m = 0; #1;
    n_cmp++; if (bus.PC_redirect !== 32'h200) begin n_bad++; $display("FAIL ecall_redir got %h want 00000200", bus.PC_redirect); end
    step();
    rd(A_MSCRATCH, v);
    n_cmp++; if (v !== 32'h14) begin n_bad++; $display("FAIL trap_drops_csr got %h want 00000014", v); end
    rd(A_MCAUSE, v);
    n_cmp++; if (v !== 32'hB) begin n_bad++; $display("FAIL ecall_mcause got %h want 0000000b", v); end
    rd(A_MEPC, v);
    n_cmp++; if (v !== 32'h54) begin n_bad++; $display("FAIL mepc_bit0 got %h want 00000054", v); end
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] v;
    bus.s_access_fault = 1; bus.bad_addr = 32'h2000; bus.epc_cur = 32'h60;
    step();
    bus.s_access_fault = 0; rst = 1;
    step();
    rst = 0; #1;
    n_cmp++; if (bus.trap_busy !== 1'b0 || bus.redirect_mux !== 1'b0) begin
      n_bad++; $display("FAIL rst_trap_outs got %b%b want 00", bus.trap_busy, bus.redirect_mux); end
    rd(A_MEPC, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_trap_mepc got %h want 0", v); end
    rd(A_MTVEC, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_trap_mtvec got %h want 0", v); end
    rd(A_MTVAL, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_trap_mtval got %h want 0", v); end
    step();
    n_cmp++; if (bus.trap_busy !== 1'b0) begin n_bad++; $display("FAIL rst_trap_stay got %b want 0", bus.trap_busy); end
  endtask

  task automatic test_store_fault_tval();
    logic [31:0] v;
    bus.s_access_fault = 1; bus.bad_addr = 32'h3008; bus.epc_cur = 32'h70;
    step();
    bus.s_access_fault = 0;
    step();
    rd(A_MTVAL, v);
    n_cmp++; if (v !== 32'h3008) begin n_bad++; $display("FAIL sfault_mtval got %h want 00003008", v); end
    rd(A_MCAUSE, v);
    n_cmp++; if (v !== 32'h7) begin n_bad++; $display("FAIL sfault_mcause got %h want 00000007", v); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exception();
    test_vectored_irq();
    test_irq_priority();
    test_mret_retrap();
    test_csr_setclear();
    test_reset_mid_trap();
    test_store_fault_tval();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
